knock_timer_bar: RTL and testbench
==================================

KNOCK_TIMER_BAR -- requirements
Module: knock_timer_bar

Interface
REQ-001 The block SHALL have parameter LED_W, default 18, meaning bar-graph LED count.
REQ-002 The block SHALL have parameter MAX_MIN, default 19, meaning minute saturation limit; MIN_W = clog2(MAX_MIN+1).
REQ-003 The block SHALL have parameter TICK_DIV, default 1000, meaning CLK1K cycles per second tick in normal mode.
REQ-004 The block SHALL have parameter FAST_DIV, default 10, meaning CLK1K cycles per second tick when FAST=1.
REQ-005 The block SHALL have parameter DEB_MS, default 8, meaning stable samples required to accept a KNOCK level.
REQ-006 The block SHALL have parameter HOLD_MS, default 1500, meaning continuous debounced-low cycles that constitute a cancel hold.
REQ-007 The block SHALL have parameter ALARM_MS, default 500, meaning ALARM assertion length in cycles.
REQ-008 The block SHALL have port CLK1K  input  1  1 kHz clock, rising edge.
REQ-009 The block SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-010 The block SHALL have port KNOCK  input  1  asynchronous knock sensor, active-low.
REQ-011 The block SHALL have port FAST  input  1  selects FAST_DIV tick.
REQ-012 The block SHALL have port PAUSE  input  1  holds countdown while high.
REQ-013 The block SHALL have port ALARM  output  1  expiry alarm, registered.
REQ-014 The block SHALL have port LED  output  LED_W  thermometer of remaining minutes, registered.
REQ-015 The block SHALL have port BUSY  output  1  high in RUN or PAUSED.
REQ-016 The block SHALL have port MIN_REMAIN  output  MIN_W  remaining minutes.

Function
REQ-017 KNOCK SHALL pass a 2-flop synchroniser, then a debouncer that updates its level only after DEB_MS consecutive equal samples.
REQ-018 A knock event SHALL be one cycle on the debounced 1->0 edge; a cancel event SHALL be one cycle when debounced-low count reaches HOLD_MS, once per press.
REQ-019 FSM states SHALL be IDLE, RUN, PAUSED, ALARM; reset state IDLE.
REQ-020 Knock in IDLE SHALL set MIN_REMAIN+1, enter RUN; knock in RUN/PAUSED SHALL add 1 minute, saturating at MAX_MIN, state unchanged.
REQ-021 Cancel in any state SHALL clear minutes, seconds, tick counter, ALARM, and enter IDLE; cancel takes priority over a same-cycle tick.
REQ-022 RUN with PAUSE=1 SHALL enter PAUSED, freezing tick counter and seconds; PAUSE=0 SHALL return to RUN.
REQ-023 In RUN the tick counter SHALL count to divisor-1 (FAST-selected at that cycle), then wrap to 0 and issue a tick.
REQ-024 On tick: SEC!=0 -> SEC-1; SEC==0 and MIN!=0 -> SEC=59, MIN-1; a decrement landing on 0:00 SHALL enter ALARM.
REQ-025 Knock coinciding with a tick SHALL apply the decrement and the increment in that same cycle.
REQ-026 ALARM state SHALL drive ALARM=1 for ALARM_MS cycles, then return to IDLE; a knock in ALARM SHALL silence it and go to IDLE without adding a minute.
REQ-027 LED SHALL be the low min(MIN_REMAIN, LED_W) bits set, updated one cycle after MIN_REMAIN changes.

Reset
REQ-028 RSTN low SHALL asynchronously force ALARM=0, LED=0, BUSY=0, MIN_REMAIN=0, seconds/tick/hold counters=0, debounced level=1, synchroniser=1, state IDLE, including mid-countdown.

Configuration
REQ-029 With macro KNOCK_TIMER_BLINK_EN defined, in RUN with MIN_REMAIN==0 and SEC!=0, LED[0] SHALL toggle on every tick; without it LED SHALL be all-zero in the last minute.

Verification
REQ-030 Reset, one clean knock, FAST=1 -> MIN_REMAIN=1, LED=1, ALARM rises exactly 60 ticks (600 cycles) after entering RUN, stays 500 cycles.
REQ-031 KNOCK glitch low for 5 cycles -> no knock event, MIN_REMAIN stays 0.
REQ-032 25 clean knocks -> MIN_REMAIN=19, LED=18'h3FFFF.
REQ-033 Knock held low 1500 cycles during RUN at 3:xx -> IDLE, MIN_REMAIN=0, LED=0, no ALARM.
REQ-034 PAUSE=1 for 2000 cycles during RUN -> seconds unchanged, BUSY=1; release resumes from same count.
REQ-035 RSTN pulsed low mid-ALARM -> ALARM=0 immediately, all outputs zero.

Source files
------------

// File: rtl/knock_timer_bar.sv
// Knock-operated countdown timer: each knock adds a minute, a long press cancels,
// remaining minutes shown as an LED bar. Define KNOCK_TIMER_BLINK_EN to blink LED[0] in the final minute.
module knock_timer_bar #(
    parameter int LED_W    = 18,
    parameter int MAX_MIN  = 19,
    parameter int TICK_DIV = 1000,
    parameter int FAST_DIV = 10,
    parameter int DEB_MS   = 8,
    parameter int HOLD_MS  = 1500,
    parameter int ALARM_MS = 500,
    localparam int MIN_W   = $clog2(MAX_MIN + 1)
) (
    input  logic             CLK1K,
    input  logic             RSTN,
    input  logic             KNOCK,
    input  logic             FAST,
    input  logic             PAUSE,
    output logic             ALARM,
    output logic [LED_W-1:0] LED,
    output logic             BUSY,
    output logic [MIN_W-1:0] MIN_REMAIN,
    output logic [1:0]       STATE_DBG
);

    localparam int DIV_MAX = (TICK_DIV > FAST_DIV) ? TICK_DIV : FAST_DIV;
    localparam int TW      = $clog2(DIV_MAX + 1);
    localparam int DW      = $clog2(DEB_MS + 1);
    localparam int HW      = $clog2(HOLD_MS + 1);
    localparam int AW      = $clog2(ALARM_MS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_ALARM  = 2'd3
    } state_t;

    logic          sync_q1;
    logic          sync_q2;
    logic          deb_level;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          deb_flip;
    logic          knock_ev;
    logic          cancel_ev;

    state_t           state_q, state_n;
    logic [MIN_W-1:0] min_q, min_n;
    logic [5:0]       sec_q, sec_n;
    logic [TW-1:0]    tick_q, tick_n;
    logic [AW-1:0]    acnt_q, acnt_n;
    logic             blink_q, blink_n;
    logic             alarm_q;
    logic [LED_W-1:0] led_q, led_n;
    logic             tick;
    logic [TW-1:0]    div_last;

    function automatic logic [MIN_W-1:0] sat_inc(input logic [MIN_W-1:0] m);
        return (m < MIN_W'(MAX_MIN)) ? m + 1'b1 : m;
    endfunction

    // Synchroniser idles high so an inactive sensor never looks like a press.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= KNOCK;
            sync_q2 <= sync_q1;
        end
    end

    assign deb_flip = (sync_q2 != deb_level) && (deb_cnt == DW'(DEB_MS - 1));

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else if (sync_q2 == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_flip) begin
            deb_level <= sync_q2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Hold counter saturates at HOLD_MS so a single press cancels only once.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            hold_cnt <= '0;
        end else if (deb_level) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HW'(HOLD_MS)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign knock_ev  = deb_flip && !sync_q2;
    assign cancel_ev = !deb_level && (hold_cnt == HW'(HOLD_MS - 1));
    assign div_last  = FAST ? TW'(FAST_DIV - 1) : TW'(TICK_DIV - 1);

    always_comb begin
        state_n = state_q;
        min_n   = min_q;
        sec_n   = sec_q;
        tick_n  = tick_q;
        acnt_n  = acnt_q;
        tick    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (knock_ev) begin
                    min_n   = sat_inc(min_q);
                    sec_n   = '0;
                    tick_n  = '0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (PAUSE) begin
                    state_n = S_PAUSED;
                end else if (tick_q >= div_last) begin
                    tick_n = '0;
                    tick   = 1'b1;
                end else begin
                    tick_n = tick_q + 1'b1;
                end
                if (tick) begin
                    if (sec_q != '0) begin
                        sec_n = sec_q - 1'b1;
                    end else if (min_q != '0) begin
                        sec_n = 6'd59;
                        min_n = min_q - 1'b1;
                    end
                end
                // A same-cycle knock is applied on top of the decrement.
                if (knock_ev) begin
                    min_n = sat_inc(min_n);
                end
                if (tick && (min_n == '0) && (sec_n == '0)) begin
                    state_n = S_ALARM;
                    acnt_n  = '0;
                end
            end
            S_PAUSED: begin
                if (!PAUSE) begin
                    state_n = S_RUN;
                end
                if (knock_ev) begin
                    min_n = sat_inc(min_q);
                end
            end
            S_ALARM: begin
                if (knock_ev || (acnt_q == AW'(ALARM_MS - 1))) begin
                    state_n = S_IDLE;
                end else begin
                    acnt_n = acnt_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (cancel_ev) begin
            state_n = S_IDLE;
            min_n   = '0;
            sec_n   = '0;
            tick_n  = '0;
            acnt_n  = '0;
        end

`ifdef KNOCK_TIMER_BLINK_EN
        blink_n = blink_q;
        if ((state_q == S_RUN) && tick && (min_q == '0) && (sec_q != '0)) begin
            blink_n = ~blink_q;
        end
        if ((state_n == S_IDLE) || (state_n == S_ALARM) || (min_n != '0)) begin
            blink_n = 1'b0;
        end
`else
        blink_n = 1'b0;
`endif
    end

    always_comb begin
        led_n = '0;
        for (int i = 0; i < LED_W; i++) begin
            led_n[i] = (int'(min_q) > i);
        end
        led_n[0] = led_n[0] | blink_q;
    end

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= '0;
            acnt_q  <= '0;
            blink_q <= 1'b0;
            alarm_q <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_n;
            min_q   <= min_n;
            sec_q   <= sec_n;
            tick_q  <= tick_n;
            acnt_q  <= acnt_n;
            blink_q <= blink_n;
            alarm_q <= (state_n == S_ALARM);
            led_q   <= led_n;
        end
    end

    assign ALARM      = alarm_q;
    assign LED        = led_q;
    assign MIN_REMAIN = min_q;
    assign BUSY       = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_knock_timer_bar.sv
// Self-checking bench for knock_timer_bar: table of knock counts, directed corner
// sequences and randomized operations against a seconds-remaining reference model.
module tb_knock_timer_bar;

    logic        CLK1K = 1'b0;
    logic        RSTN  = 1'b0;
    logic        KNOCK = 1'b1;
    logic        FAST  = 1'b0;
    logic        PAUSE = 1'b0;
    logic        ALARM;
    logic [17:0] LED;
    logic        BUSY;
    logic [4:0]  MIN_REMAIN;
    logic [1:0]  STATE_DBG;

    int n_checks = 0;
    int n_pass   = 0;
    int rise;
    int fall;

    // Reference model: state 0 idle, 1 counting (incl. paused), 2 alarming; time as total seconds.
    int m_st;
    int m_R;
    int m_run_cyc;
    bit m_paused;
    int m_alarm_left;
    int m_led_min;

    typedef struct {
        int          n_knocks;
        logic [4:0]  exp_min;
        logic [17:0] exp_led;
    } vec_t;
    vec_t vecs[6];

    always #5 CLK1K = ~CLK1K;

    knock_timer_bar dut (
        .CLK1K      (CLK1K),
        .RSTN       (RSTN),
        .KNOCK      (KNOCK),
        .FAST       (FAST),
        .PAUSE      (PAUSE),
        .ALARM      (ALARM),
        .LED        (LED),
        .BUSY       (BUSY),
        .MIN_REMAIN (MIN_REMAIN),
        .STATE_DBG  (STATE_DBG)
    );

    function automatic int thermo(input int m);
        int k;
        k = (m > 18) ? 18 : m;
        return (1 << k) - 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic model_edge(input bit kev);
        int  div;
        int  mm;
        int  ss;
        bit  ticked;
        m_led_min = m_R / 60;
        div       = FAST ? 10 : 1000;
        ticked    = 1'b0;
        case (m_st)
            0: begin
                if (kev) begin
                    m_R = 60; m_st = 1; m_run_cyc = 0; m_paused = 1'b0;
                end
            end
            1: begin
                if (m_paused) begin
                    if (!PAUSE) m_paused = 1'b0;
                end else if (PAUSE) begin
                    m_paused = 1'b1;
                end else begin
                    m_run_cyc++;
                    if (m_run_cyc >= div) begin
                        m_run_cyc = 0;
                        ticked    = 1'b1;
                        if (m_R > 0) m_R--;
                    end
                end
                if (kev) begin
                    mm = m_R / 60;
                    ss = m_R % 60;
                    if (mm < 19) mm++;
                    m_R = mm * 60 + ss;
                end
                if (ticked && m_R == 0) begin
                    m_st = 2; m_alarm_left = 500;
                end
            end
            default: begin
                if (kev) m_st = 0;
                else begin
                    m_alarm_left--;
                    if (m_alarm_left == 0) m_st = 0;
                end
            end
        endcase
    endtask

    task automatic cyc(input bit kev);
        @(posedge CLK1K);
        model_edge(kev);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    // A clean press: the event lands on the 10th edge (2 sync flops + DEB_MS samples).
    task automatic do_knock();
        KNOCK = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            cyc(c == 10);
            if (c == 12) KNOCK = 1'b1;
        end
    endtask

    task automatic do_reset();
        RSTN  = 1'b0;
        KNOCK = 1'b1;
        PAUSE = 1'b0;
        repeat (2) @(posedge CLK1K);
        #1 RSTN = 1'b1;
        m_st = 0; m_R = 0; m_run_cyc = 0; m_paused = 1'b0; m_alarm_left = 0; m_led_min = 0;
    endtask

    task automatic check_model();
        chk("rnd_min",   MIN_REMAIN, m_R / 60);
        chk("rnd_led",   LED,        thermo(m_led_min));
        chk("rnd_busy",  BUSY,       m_st == 1);
        chk("rnd_alarm", ALARM,      m_st == 2);
    endtask

    initial begin
        vecs[0] = '{1,  5'd1,  18'h00001};
        vecs[1] = '{2,  5'd2,  18'h00003};
        vecs[2] = '{5,  5'd5,  18'h0001F};
        vecs[3] = '{18, 5'd18, 18'h3FFFF};
        vecs[4] = '{19, 5'd19, 18'h3FFFF};
        vecs[5] = '{25, 5'd19, 18'h3FFFF};

        do_reset();
        chk("rst_alarm", ALARM, 0);
        chk("rst_led",   LED,   0);
        chk("rst_busy",  BUSY,  0);
        chk("rst_min",   MIN_REMAIN, 0);

        // Knock counts with saturation at MAX_MIN; slow tick so no second elapses.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            FAST = 1'b0;
            for (int k = 0; k < vecs[v].n_knocks; k++) do_knock();
            step(2);
            chk("tbl_min",  MIN_REMAIN, vecs[v].exp_min);
            chk("tbl_led",  LED,        vecs[v].exp_led);
            chk("tbl_busy", BUSY,       1);
        end

        // Asynchronous reset mid-countdown.
        #2 RSTN = 1'b0;
        #1;
        chk("arst_run_min",  MIN_REMAIN, 0);
        chk("arst_run_led",  LED,        0);
        chk("arst_run_busy", BUSY,       0);

        // Glitch widths around the debounce threshold.
        for (int g = 5; g <= 8; g++) begin
            if (g == 6) continue;
            do_reset();
            FAST  = 1'b0;
            KNOCK = 1'b0;
            step(g);
            KNOCK = 1'b1;
            step(30);
            chk("glitch_min", MIN_REMAIN, (g == 8) ? 1 : 0);
        end

        // One knock, fast tick: alarm after exactly 600 cycles, lasting 500.
        do_reset();
        FAST  = 1'b1;
        KNOCK = 1'b0;
        rise  = -1;
        fall  = -1;
        for (int e = 1; e <= 1200; e++) begin
            cyc(e == 10);
            if (e == 12) KNOCK = 1'b1;
            if (e == 10) begin
                chk("fast_min_e10", MIN_REMAIN, 1);
                chk("fast_led_lag", LED,        0);
            end
            if (e == 11) chk("fast_led_e11", LED, 1);
            if (e == 21) chk("fast_led_e21", LED, 0);
            if (e == 300) begin
                chk("fast_min_last", MIN_REMAIN, 0);
                chk("fast_led_last", LED,        0);
                chk("fast_busy",     BUSY,       1);
            end
            if (ALARM && rise < 0) rise = e;
            if (!ALARM && rise >= 0 && fall < 0) fall = e;
        end
        chk("alarm_rise_edge", rise, 610);
        chk("alarm_fall_edge", fall, 1110);
        chk("alarm_end_busy",  BUSY, 0);

        // Long press during a multi-minute countdown cancels after HOLD_MS low cycles.
        do_reset();
        FAST = 1'b0;
        repeat (3) do_knock();
        KNOCK = 1'b0;
        for (int e = 1; e <= 1520; e++) begin
            cyc(e == 10);
            if (e == 20)   chk("hold_min_add", MIN_REMAIN, 4);
            if (e == 1509) chk("hold_busy_pre", BUSY, 1);
            if (e == 1510) begin
                chk("hold_busy_post", BUSY,       0);
                chk("hold_min_post",  MIN_REMAIN, 0);
            end
        end
        chk("hold_led",   LED,   0);
        chk("hold_alarm", ALARM, 0);
        KNOCK = 1'b1;
        step(30);
        chk("hold_release_busy", BUSY, 0);

        // Pause for 2000 cycles shifts the alarm by 2000 plus the resume cycle.
        do_reset();
        FAST  = 1'b1;
        KNOCK = 1'b0;
        rise  = -1;
        for (int e = 1; e <= 2700; e++) begin
            cyc(e == 10);
            if (e == 12)   KNOCK = 1'b1;
            if (e == 100)  PAUSE = 1'b1;
            if (e == 2100) PAUSE = 1'b0;
            if (e == 1000) begin
                chk("pause_busy",  BUSY,  1);
                chk("pause_alarm", ALARM, 0);
            end
            if (ALARM && rise < 0) rise = e;
        end
        chk("pause_rise_edge", rise, 2611);

        // Knock during alarm silences it without adding a minute.
        do_reset();
        FAST = 1'b1;
        do_knock();
        step(600);
        chk("silence_pre", ALARM, 1);
        do_knock();
        chk("silence_alarm", ALARM,      0);
        chk("silence_min",   MIN_REMAIN, 0);
        chk("silence_busy",  BUSY,       0);

        // Asynchronous reset mid-alarm.
        do_reset();
        FAST = 1'b1;
        do_knock();
        step(650);
        chk("arst_alarm_pre", ALARM, 1);
        #2 RSTN = 1'b0;
        #1;
        chk("arst_alarm", ALARM,      0);
        chk("arst_led",   LED,        0);
        chk("arst_busy",  BUSY,       0);
        chk("arst_min",   MIN_REMAIN, 0);

        // Randomized operation sequences against the reference model.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            FAST = 1'b1;
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 3))
                    0, 1: do_knock();
                    2:    step($urandom_range(5, 300));
                    default: begin
                        PAUSE = 1'b1;
                        step($urandom_range(5, 80));
                        PAUSE = 1'b0;
                        step(1);
                    end
                endcase
                check_model();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
